// File: rtl/sram_be_pipe.sv
// Single-port synchronous SRAM bank with byte enables, 1- or 2-cycle registered read,
// post-reset clear sequencer and out-of-range detection.
module sram_be_pipe #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    ADDRESS_WIDTH  = 13,
   parameter int                    RAM_DEPTH      = 8192,
   parameter int                    READ_LATENCY   = 1,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input  logic                      sram_clk,
   input  logic                      sram_rst,
   input  logic [ADDRESS_WIDTH-1:0]  sram_address,
   input  logic [DATA_WIDTH-1:0]     sram_data_i,
   input  logic [DATA_WIDTH/8-1:0]   sram_be,
   input  logic                      sram_cs,
   input  logic                      sram_we,
   input  logic                      sram_oe,
   output logic [DATA_WIDTH-1:0]     sram_data_o,
   output logic                      sram_oe_r,
   output logic                      sram_err,
   output logic                      sram_ready
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH + 1)'(RAM_DEPTH);
   localparam logic [ADDRESS_WIDTH:0] LAST_C  = DEPTH_C - (ADDRESS_WIDTH + 1)'(1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   logic [DATA_WIDTH-1:0]  mem_r [RAM_DEPTH];

   state_t                 state_r;
   state_t                 state_next_s;
   logic [ADDRESS_WIDTH:0] clr_cnt_r;
   logic                   clr_we_s;
   logic                   ready_r;

   logic                   in_range_s;
   logic                   wr_acc_s;
   logic                   rd_acc_s;
   logic                   wr_oor_s;
   logic                   rd_oor_s;
   logic [DATA_WIDTH-1:0]  rd_word_s;

   logic                   out_v_s;
   logic                   out_oor_s;
   logic [DATA_WIDTH-1:0]  out_data_s;

   // Clear sequencer next-state and clear-write strobe
   always_comb begin
      state_next_s = state_r;
      clr_we_s     = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            clr_we_s = ~sram_rst;
            if (clr_cnt_r == LAST_C) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = RESET_STATE;
         end
      endcase
   end

   // Sequencer state, clear counter and ready flag
   always_ff @(posedge sram_clk) begin
      if (sram_rst) begin
         state_r   <= RESET_STATE;
         clr_cnt_r <= '0;
         ready_r   <= 1'b0;
      end else begin
         state_r <= state_next_s;
         if (clr_we_s) begin
            clr_cnt_r <= clr_cnt_r + (ADDRESS_WIDTH + 1)'(1);
         end
         ready_r <= (state_next_s == ST_IDLE);
      end
   end

   assign sram_ready = ready_r;

   // Bus accept decode; range compare is one bit wider than the address so no wrap is possible
   always_comb begin
      in_range_s = ({1'b0, sram_address} < DEPTH_C);
      wr_acc_s   = ready_r & sram_cs & sram_we & ~sram_rst;
      rd_acc_s   = ready_r & sram_cs & ~sram_we & sram_oe & ~sram_rst;
      wr_oor_s   = wr_acc_s & ~in_range_s;
      rd_oor_s   = rd_acc_s & ~in_range_s;
      if (rd_acc_s && in_range_s) begin
         rd_word_s = mem_r[sram_address];
      end else begin
         rd_word_s = '0;
      end
   end

   // Storage array: clear writes take priority, bus writes merge per enabled byte
   always_ff @(posedge sram_clk) begin
      if (clr_we_s) begin
         mem_r[clr_cnt_r[ADDRESS_WIDTH-1:0]] <= CLEAR_VALUE;
      end else if (wr_acc_s && in_range_s) begin
         for (int i = 0; i < BYTES; i++) begin
            if (sram_be[i]) begin
               mem_r[sram_address][8*i +: 8] <= sram_data_i[8*i +: 8];
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  s1_v_r;
         logic                  s1_oor_r;
         logic [DATA_WIDTH-1:0] s1_data_r;

         // Extra read stage between the array and the output register
         always_ff @(posedge sram_clk) begin
            if (sram_rst) begin
               s1_v_r    <= 1'b0;
               s1_oor_r  <= 1'b0;
               s1_data_r <= '0;
            end else begin
               s1_v_r   <= rd_acc_s;
               s1_oor_r <= rd_oor_s;
               if (rd_acc_s) begin
                  s1_data_r <= rd_word_s;
               end
            end
         end

         assign out_v_s    = s1_v_r;
         assign out_oor_s  = s1_oor_r;
         assign out_data_s = s1_data_r;
      end else begin : g_lat1
         assign out_v_s    = rd_acc_s;
         assign out_oor_s  = rd_oor_s;
         assign out_data_s = rd_word_s;
      end
   endgenerate

   // Output register: data holds between reads, strobes last one cycle
   always_ff @(posedge sram_clk) begin
      if (sram_rst) begin
         sram_data_o <= '0;
         sram_oe_r   <= 1'b0;
         sram_err    <= 1'b0;
      end else begin
         sram_oe_r <= out_v_s;
         sram_err  <= out_oor_s | wr_oor_s;
         if (out_v_s) begin
            sram_data_o <= out_data_s;
         end
      end
   end

endmodule
